// File: rtl/clock_pkg.sv
// Shared definitions for the VGA clock front end: button channel indices,
// the per-button FSM state type and default timing for a 25 MHz video_clk.
package clock_pkg;

    // Button channel order on btn_in / btn_level / btn_pulse
    localparam int BTN_HOUR   = 0;
    localparam int BTN_MIN    = 1;
    localparam int BTN_SEC    = 2;
    localparam int BTN_AL     = 3;
    localparam int BTN_AL_TOG = 4;

    localparam int DEF_NUM_BTN = 5;

    // Default timing: 25000 cycles of 25 MHz is one 1 ms tick
    localparam int DEF_TICK_DIV         = 25000;
    localparam int DEF_DEBOUNCE_MS      = 10;
    localparam int DEF_REPEAT_DELAY_MS  = 500;
    localparam int DEF_REPEAT_PERIOD_MS = 100;

    // Only the time-setting buttons auto-repeat; alarm buttons pulse once
    localparam logic [DEF_NUM_BTN-1:0] DEF_REPEAT_MASK =
        DEF_NUM_BTN'((1 << BTN_HOUR) | (1 << BTN_MIN) | (1 << BTN_SEC));

    // Per-button press/repeat state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } btn_state_t;

    // Bits needed to hold 0..max_count inclusive
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, tick-based debounce and the
// press / auto-repeat FSM producing registered one-cycle pulses.
// Handshake: none; pulse_o is a one-cycle strobe with no back-pressure,
// level_o is a plain debounced level.
module btn_channel
    import clock_pkg::*;
#(
    parameter int   DEBOUNCE_MS      = DEF_DEBOUNCE_MS,
    parameter int   REPEAT_DELAY_MS  = DEF_REPEAT_DELAY_MS,
    parameter int   REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS,
    parameter logic REPEAT_EN        = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int DB_W   = cnt_width(DEBOUNCE_MS);
    localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int RP_W   = cnt_width(RP_MAX);

    // Counters act on the tick that would make them reach their terminal value
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY_MS - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD_MS - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
    logic            pulse_q, pulse_d;
    btn_state_t      state_q, state_d;
    logic            rise, fall;

    // Synchronizer, debounce and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            rp_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            rp_cnt_q <= rp_cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Debounce: level flips only after DEBOUNCE_MS consecutive disagreeing ticks
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Edges of the debounced level as they are about to be registered
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; release is checked before any repeat event
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = REPEAT_EN ? ST_DELAY : ST_HELD;
            end
            ST_DELAY: begin
                if (fall) state_d = ST_IDLE;
                else if (tick_i && (rp_cnt_q == DELAY_LAST)) state_d = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (fall) state_d = ST_IDLE;
            end
            ST_HELD: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: press/repeat pulse and the repeat tick counter
    always_comb begin
        pulse_d  = 1'b0;
        rp_cnt_d = rp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                rp_cnt_d = '0;
                if (rise) pulse_d = 1'b1;
            end
            ST_DELAY: begin
                if (fall) begin
                    rp_cnt_d = '0;
                end else if (tick_i) begin
                    if (rp_cnt_q == DELAY_LAST) begin
                        pulse_d  = 1'b1;
                        rp_cnt_d = '0;
                    end else begin
                        rp_cnt_d = rp_cnt_q + RP_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    rp_cnt_d = '0;
                end else if (tick_i) begin
                    if (rp_cnt_q == PERIOD_LAST) begin
                        pulse_d  = 1'b1;
                        rp_cnt_d = '0;
                    end else begin
                        rp_cnt_d = rp_cnt_q + RP_W'(1);
                    end
                end
            end
            ST_HELD: begin
                rp_cnt_d = '0;
            end
            default: rp_cnt_d = '0;
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the VGA clock core: a shared 1 ms prescaler
// feeding one debounce/auto-repeat channel per button.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int                 NUM_BTN          = DEF_NUM_BTN,
    parameter int                 TICK_DIV         = DEF_TICK_DIV,
    parameter int                 DEBOUNCE_MS      = DEF_DEBOUNCE_MS,
    parameter int                 REPEAT_DELAY_MS  = DEF_REPEAT_DELAY_MS,
    parameter int                 REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK      = DEF_REPEAT_MASK
) (
    input  logic               video_clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    localparam int TD_W = cnt_width(TICK_DIV - 1);
    localparam logic [TD_W-1:0] TICK_LAST = TD_W'(TICK_DIV - 1);

    logic [TD_W-1:0] presc_q, presc_d;
    logic            tick;

    assign tick = (presc_q == TICK_LAST);

    // Prescaler next value: wrap after the tick cycle
    always_comb begin
        presc_d = tick ? '0 : presc_q + TD_W'(1);
    end

    // Prescaler register
    always_ff @(posedge video_clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_MS      (DEBOUNCE_MS),
            .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
            .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS),
            .REPEAT_EN        (REPEAT_MASK[g])
        ) u_ch (
            .clk_i   (video_clk),
            .rst_i   (reset),
            .tick_i  (tick),
            .btn_i   (btn_in[g]),
            .level_o (btn_level[g]),
            .pulse_o (btn_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing (tick every 4 cycles).
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int TD = 4;
    localparam int DEB = 3;
    localparam int RD = 5;
    localparam int RP = 2;
    localparam logic [NB-1:0] RMASK = 5'b00111;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN          (NB),
        .TICK_DIV         (TD),
        .DEBOUNCE_MS      (DEB),
        .REPEAT_DELAY_MS  (RD),
        .REPEAT_PERIOD_MS (RP),
        .REPEAT_MASK      (RMASK)
    ) dut (
        .video_clk (clk),
        .reset     (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    // Reference model: outputs expected after each rising edge.
    // Ticks come from the cycle count since reset; a press is the debounced
    // rise; repeats fire when ticks-held equals RD + k*RP.
    logic [NB-1:0] m_h1, m_h2, m_level, m_pulse;
    int m_cyc;
    int m_dis [NB];
    int m_held[NB];

    always @(posedge clk) begin : model
        logic [NB-1:0] sync;
        logic tick;
        logic prev;
        if (rst) begin
            m_h1 = '0; m_h2 = '0; m_level = '0; m_pulse = '0; m_cyc = 0;
            for (int n = 0; n < NB; n++) begin
                m_dis[n] = 0;
                m_held[n] = 0;
            end
        end else begin
            tick = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            sync = m_h2;
            m_h2 = m_h1;
            m_h1 = btn_in;
            m_pulse = '0;
            for (int n = 0; n < NB; n++) begin
                prev = m_level[n];
                if (sync[n] != m_level[n]) begin
                    if (tick) begin
                        m_dis[n]++;
                        if (m_dis[n] == DEB) begin
                            m_level[n] = sync[n];
                            m_dis[n] = 0;
                        end
                    end
                end else begin
                    m_dis[n] = 0;
                end
                if (m_level[n] && !prev) begin
                    m_pulse[n] = 1'b1;
                    m_held[n] = 0;
                end else if (m_level[n] && prev && RMASK[n] && tick) begin
                    m_held[n]++;
                    if (m_held[n] >= RD && ((m_held[n] - RD) % RP) == 0) m_pulse[n] = 1'b1;
                end
            end
        end
    end

    // Driver: one reset cycle with all buttons released
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int first_pulse[NB];
        int rise_cyc[NB];
        int npulse[NB];
        logic [NB-1:0] prev_level;
        btn_in = 5'b11111;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== '0 || btn_pulse !== '0) begin
                errors++;
                $display("FAIL reset_hold level=%b pulse=%b expected 0/0", btn_level, btn_pulse);
            end
        end
        rst = 1'b0;
        prev_level = '0;
        for (int n = 0; n < NB; n++) begin
            first_pulse[n] = -1; rise_cyc[n] = -1; npulse[n] = 0;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL reset_model cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
            if (i == 1) begin
                checks++;
                if (btn_level !== '0 || btn_pulse !== '0) begin
                    errors++;
                    $display("FAIL reset_after level=%b pulse=%b expected 0/0", btn_level, btn_pulse);
                end
            end
            for (int n = 0; n < NB; n++) begin
                if (btn_pulse[n] === 1'b1) begin
                    npulse[n]++;
                    if (first_pulse[n] < 0) first_pulse[n] = i;
                end
                if (btn_level[n] === 1'b1 && prev_level[n] === 1'b0 && rise_cyc[n] < 0) rise_cyc[n] = i;
            end
            prev_level = btn_level;
        end
        for (int n = 0; n < NB; n++) begin
            checks++;
            if (rise_cyc[n] < 11 || rise_cyc[n] > 14 || first_pulse[n] != rise_cyc[n] || npulse[n] != 1) begin
                errors++;
                $display("FAIL reset_press ch=%0d rise=%0d pulse_at=%0d pulses=%0d expected rise 11..14 with one coincident pulse",
                         n, rise_cyc[n], first_pulse[n], npulse[n]);
            end
        end
    endtask

    task automatic test_bounce();
        int countdown;
        do_reset();
        countdown = 5;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
            checks++;
            if (btn_level[0] !== 1'b0 || btn_pulse[0] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_ch0 cyc=%0d level=%b pulse=%b expected 0 0", i, btn_level[0], btn_pulse[0]);
            end
            if (i < 120) begin
                countdown--;
                if (countdown == 0) begin
                    btn_in[0] = ~btn_in[0];
                    countdown = (i < 60) ? 5 : $urandom_range(1, 5);
                end
            end else begin
                btn_in[0] = 1'b0;
            end
        end
    endtask

    task automatic test_repeat();
        int pq[$];
        int hold;
        int bad_rel;
        do_reset();
        hold = 80 + $urandom_range(0, 8);
        bad_rel = 0;
        btn_in[1] = 1'b1;
        for (int i = 0; i < hold + 40; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL repeat_model cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
            if (btn_pulse[1] === 1'b1) begin
                pq.push_back(i);
                if (btn_level[1] !== 1'b1) bad_rel++;
            end
            if (i == hold - 1) btn_in[1] = 1'b0;
        end
        checks++;
        if (pq.size() < 3 || bad_rel != 0) begin
            errors++;
            $display("FAIL repeat_count pulses=%0d after_release=%0d expected >=3 and 0", pq.size(), bad_rel);
        end else begin
            checks++;
            if (pq[1] - pq[0] != RD * TD) begin
                errors++;
                $display("FAIL repeat_first_gap got=%0d expected=%0d", pq[1] - pq[0], RD * TD);
            end
            for (int k = 2; k < pq.size(); k++) begin
                checks++;
                if (pq[k] - pq[k-1] != RP * TD) begin
                    errors++;
                    $display("FAIL repeat_gap k=%0d got=%0d expected=%0d", k, pq[k] - pq[k-1], RP * TD);
                end
            end
        end
    endtask

    task automatic test_non_repeat();
        int npulse;
        logic seen;
        do_reset();
        npulse = 0;
        seen = 1'b0;
        btn_in[3] = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL nonrep_model cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
            if (btn_pulse[3] === 1'b1) begin
                npulse++;
                seen = 1'b1;
            end
            if (seen && i < 100) begin
                checks++;
                if (btn_level[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL nonrep_level cyc=%0d got=%b expected 1", i, btn_level[3]);
                end
            end
            if (i == 99) btn_in[3] = 1'b0;
        end
        checks++;
        if (npulse != 1 || btn_level[3] !== 1'b0) begin
            errors++;
            $display("FAIL nonrep_pulses got=%0d level=%b expected 1 pulse and level 0", npulse, btn_level[3]);
        end
    endtask

    task automatic test_release_in_delay();
        int found;
        int extra;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            btn_in[2] = 1'b1;
            found = 0;
            for (int i = 0; i < 30 && found == 0; i++) begin
                @(negedge clk);
                checks++;
                if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                    errors++;
                    $display("FAIL rel_model r=%0d cyc=%0d level=%b pulse=%b expected %b %b", round, i, btn_level, btn_pulse, m_level, m_pulse);
                end
                if (btn_pulse[2] === 1'b1) found = 1;
            end
            checks++;
            if (found == 0) begin
                errors++;
                $display("FAIL rel_press_timeout r=%0d no pulse within 30 cycles", round);
            end
            extra = 0;
            for (int i = 1; i <= 50; i++) begin
                @(negedge clk);
                checks++;
                if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                    errors++;
                    $display("FAIL rel_model2 r=%0d cyc=%0d level=%b pulse=%b expected %b %b", round, i, btn_level, btn_pulse, m_level, m_pulse);
                end
                if (btn_pulse[2] === 1'b1) extra++;
                if (i == ((round == 0) ? 8 : 4)) btn_in[2] = 1'b0;
            end
            checks++;
            if (extra != 0 || btn_level[2] !== 1'b0) begin
                errors++;
                $display("FAIL rel_no_repeat r=%0d extra=%0d level=%b expected 0 and 0", round, extra, btn_level[2]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int hold;
        int npulse;
        do_reset();
        hold = $urandom_range(40, 60);
        npulse = 0;
        btn_in = 5'b00101;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL simul_model cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
            checks++;
            if (btn_pulse[0] !== btn_pulse[2]) begin
                errors++;
                $display("FAIL simul_align cyc=%0d pulse0=%b pulse2=%b expected equal", i, btn_pulse[0], btn_pulse[2]);
            end
            if (btn_pulse[0] === 1'b1) npulse++;
        end
        checks++;
        if (npulse < 2) begin
            errors++;
            $display("FAIL simul_repeat pulses=%0d expected >=2 before reset", npulse);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (btn_level !== '0 || btn_pulse !== '0) begin
            errors++;
            $display("FAIL simul_reset level=%b pulse=%b expected 0/0", btn_level, btn_pulse);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL simul_post cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_pulse} !== {m_level, m_pulse}) begin
                errors++;
                $display("FAIL random_model cyc=%0d level=%b pulse=%b expected %b %b", i, btn_level, btn_pulse, m_level, m_pulse);
            end
            if ($urandom_range(0, 15) == 0) btn_in[$urandom_range(0, NB - 1)] ^= 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_in = '0;
        test_reset();
        test_bounce();
        test_repeat();
        test_non_repeat();
        test_release_in_delay();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
